hl_load_sequencer: RTL and testbench

Controller that sequences the split-half word register (`register_hl`, parameter N). It accepts a byte stream of N/2-bit halves over a valid/ready handshake, steers the first byte of each pair into the high half and the second into the low half, and presents the assembled word downstream with a valid/ready handshake. After each word is consumed it clears the register, and it aborts a half-written word on timeout. It sits between the byte-serial input path and the consumer of the N-bit word.

---
 rtl/hl_load_sequencer.sv | 90 +++++++++
 tb/tb_hl_load_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hl_load_sequencer.sv
// rtl/hl_load_sequencer.sv - pairs a half-word byte stream into register_hl and hands the word downstream
// High byte first, low byte second; the register is cleared after every consume or timeout abort.
module hl_load_sequencer #(
  parameter int N       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [N/2-1:0]   in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N/2-1:0]   reg_inh,
  output logic [N/2-1:0]   reg_inl,
  output logic             reg_loadh,
  output logic             reg_loadl,
  output logic             reg_clr,
  input  logic [N-1:0]     reg_out,
  output logic [N-1:0]     word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             timeout_err,
  output logic [7:0]       word_count
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, HAVE_H, FULL, CLR} state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic          accept;

  assign in_ready   = (state == IDLE) || (state == HAVE_H);
  assign accept     = in_valid & in_ready;
  assign reg_inh    = in_byte;
  assign reg_inl    = in_byte;
  assign reg_loadh  = accept & (state == IDLE);
  assign reg_loadl  = accept & (state == HAVE_H);
  assign word       = reg_out;
  assign word_valid = (state == FULL);

  // reg_clr feeds the register's async clear, so it must come straight from a flop
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      tcnt        <= '0;
      reg_clr     <= 1'b0;
      timeout_err <= 1'b0;
      word_count  <= 8'd0;
    end else begin
      reg_clr     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= HAVE_H;
            tcnt  <= '0;
          end
        end
        HAVE_H: begin
          // a low byte arriving on the limit cycle still completes the word
          if (accept) begin
            state <= FULL;
          end else if (tcnt == LIMIT) begin
            state       <= CLR;
            reg_clr     <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        FULL: begin
          if (word_ready) begin
            state      <= CLR;
            reg_clr    <= 1'b1;
            word_count <= word_count + 8'd1;
          end
        end
        CLR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hl_load_sequencer.sv
// tb/tb_hl_load_sequencer.sv - table vectors, reset corners and randomized pairs against a word model
module tb_hl_load_sequencer;

  logic        clk;
  logic        clear;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  reg_inh;
  logic [7:0]  reg_inl;
  logic        reg_loadh;
  logic        reg_loadl;
  logic        reg_clr;
  logic [15:0] reg_out;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        timeout_err;
  logic [7:0]  word_count;

  hl_load_sequencer #(.N(16), .TIMEOUT(4)) dut (
    .clk(clk), .clear(clear), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .reg_inh(reg_inh), .reg_inl(reg_inl), .reg_loadh(reg_loadh), .reg_loadl(reg_loadl),
    .reg_clr(reg_clr), .reg_out(reg_out), .word(word), .word_valid(word_valid),
    .word_ready(word_ready), .timeout_err(timeout_err), .word_count(word_count)
  );

  // split-half register the sequencer drives
  logic [15:0] reg_q;
  assign reg_out = reg_q;
  always @(posedge clk or posedge reg_clr or posedge clear) begin
    if (reg_clr || clear) reg_q <= 16'h0000;
    else begin
      if (reg_loadh) reg_q[15:8] <= reg_inh;
      if (reg_loadl) reg_q[7:0]  <= reg_inl;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [7:0]  b;
    logic        wr;
    logic        er;
    logic        ewv;
    logic [15:0] ew;
    logic        eclr;
    logic        eto;
    logic [7:0]  ecnt;
    logic        elh;
    logic        ell;
  } vec_t;

  vec_t tbl[$];
  int   mc;
  int   nvec;
  int   nmis;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [7:0] b, input logic wr, input logic er,
                     input logic ewv, input logic [15:0] ew, input logic eclr, input logic eto,
                     input logic elh, input logic ell);
    vec_t v;
    v.iv = iv; v.b = b; v.wr = wr; v.er = er; v.ewv = ewv; v.ew = ew;
    v.eclr = eclr; v.eto = eto; v.ecnt = 8'(mc); v.elh = elh; v.ell = ell;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // one full word starting in IDLE at a falling edge; ends in IDLE at a falling edge
  task automatic do_word(input logic [7:0] hi, input logic [7:0] lo, input int gap, input int hold);
    logic [15:0] expw;
    expw = {hi, lo};
    in_valid = 1'b1; in_byte = hi; word_ready = 1'($urandom);
    #1;
    chk("rnd_ready_hi", in_ready, 1);
    chk("rnd_loadh", {reg_loadh, reg_loadl}, 2'b10);
    tick();
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0; in_byte = 8'($urandom);
      #1;
      chk("rnd_gap_ready", in_ready, 1);
      chk("rnd_gap_word", word, {hi, 8'h00});
      chk("rnd_gap_to", timeout_err, 0);
      tick();
    end
    in_valid = 1'b1; in_byte = lo;
    #1;
    chk("rnd_loadl", {reg_loadh, reg_loadl}, 2'b01);
    tick();
    for (int h = 0; h <= hold; h++) begin
      in_valid = 1'($urandom); in_byte = 8'($urandom); word_ready = (h == hold);
      #1;
      chk("rnd_valid", word_valid, 1);
      chk("rnd_word", word, expw);
      chk("rnd_full_ready", in_ready, 0);
      chk("rnd_full_loads", {reg_loadh, reg_loadl}, 2'b00);
      chk("rnd_count", word_count, 16'(mc & 255));
      tick();
    end
    mc++;
    in_valid = 1'($urandom); in_byte = 8'($urandom); word_ready = 1'b0;
    #1;
    chk("rnd_clr", reg_clr, 1);
    chk("rnd_clr_word", word, 16'h0000);
    chk("rnd_clr_ready", in_ready, 0);
    chk("rnd_clr_valid", word_valid, 0);
    chk("rnd_count_inc", word_count, 16'(mc & 255));
    tick();
    in_valid = 1'b0;
    #1;
    chk("rnd_idle_ready", in_ready, 1);
    chk("rnd_idle_clr", reg_clr, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_valid"}, word_valid, 0);
    chk({tag, "_clr"}, reg_clr, 0);
    chk({tag, "_to"}, timeout_err, 0);
    chk({tag, "_count"}, word_count, 0);
    chk({tag, "_loads"}, {reg_loadh, reg_loadl}, 2'b00);
  endtask

  initial begin
    nvec = 0; nmis = 0; mc = 0;
    clear = 1'b1; in_valid = 1'b0; in_byte = 8'h00; word_ready = 1'b0;

    // basic pair with immediate consume
    add(1, 8'hAB, 1, 1, 0, 16'h0000, 0, 0, 1, 0);
    add(1, 8'hCD, 1, 1, 0, 16'hAB00, 0, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, 16'hABCD, 0, 0, 0, 0); mc++;
    add(0, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
    // consumer stalls for 10 cycles with ignored input pulses
    add(1, 8'h12, 0, 1, 0, 16'h0000, 0, 0, 1, 0);
    add(1, 8'h34, 0, 1, 0, 16'h1200, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++)
      add(logic'(i % 2 == 0), 8'(8'hE0 + i), 0, 0, 1, 16'h1234, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 16'h1234, 0, 0, 0, 0); mc++;
    add(0, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
    // timeout abort after a lone high byte
    add(1, 8'h55, 0, 1, 0, 16'h0000, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      add(0, 8'h00, 0, 1, 0, 16'h5500, 0, 0, 0, 0);
    add(1, 8'h77, 0, 0, 0, 16'h0000, 1, 1, 0, 0);
    add(0, 8'h00, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
    add(1, 8'h01, 1, 1, 0, 16'h0000, 0, 0, 1, 0);
    add(1, 8'h02, 1, 1, 0, 16'h0100, 0, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, 16'h0102, 0, 0, 0, 0); mc++;
    add(0, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 16'h0000, 0, 0, 0, 0);
    // low byte on the final timeout cycle wins
    add(1, 8'h66, 0, 1, 0, 16'h0000, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      add(0, 8'h00, 0, 1, 0, 16'h6600, 0, 0, 0, 0);
    add(1, 8'h77, 0, 1, 0, 16'h6600, 0, 0, 0, 1);
    add(0, 8'h00, 0, 0, 1, 16'h6677, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 16'h6677, 0, 0, 0, 0); mc++;
    add(0, 8'h00, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 16'h0000, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk_reset("por");
    clear = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_byte = tbl[i].b; word_ready = tbl[i].wr;
      #1;
      chk($sformatf("row%0d_ready", i), in_ready, tbl[i].er);
      chk($sformatf("row%0d_valid", i), word_valid, tbl[i].ewv);
      chk($sformatf("row%0d_word", i), word, tbl[i].ew);
      chk($sformatf("row%0d_clr", i), reg_clr, tbl[i].eclr);
      chk($sformatf("row%0d_to", i), timeout_err, tbl[i].eto);
      chk($sformatf("row%0d_count", i), word_count, tbl[i].ecnt);
      chk($sformatf("row%0d_loads", i), {reg_loadh, reg_loadl}, {tbl[i].elh, tbl[i].ell});
      tick();
    end

    // reset while holding a high byte
    in_valid = 1'b1; in_byte = 8'h9A; word_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    chk("have_h_word", word, 16'h9A00);
    clear = 1'b1;
    #1;
    chk_reset("rst_have_h");
    chk("rst_have_h_word", word, 16'h0000);
    #1 clear = 1'b0;
    mc = 0;
    @(negedge clk);
    do_word(8'h3C, 8'hC3, 0, 0);

    // reset while a word is held
    tick();
    in_valid = 1'b1; in_byte = 8'h5A;
    tick();
    in_byte = 8'hA5;
    tick();
    in_valid = 1'b0;
    #1;
    chk("full_before_rst", word_valid, 1);
    clear = 1'b1;
    #1;
    chk_reset("rst_full");
    #1 clear = 1'b0;
    mc = 0;
    @(negedge clk);
    do_word(8'h0F, 8'hF0, 1, 1);

    // randomized pairs with 0-3 idle gaps, past the counter wrap
    for (int w = 0; w < 260; w++) begin
      int pre;
      pre = int'($urandom_range(0, 3));
      for (int p = 0; p < pre; p++) tick();
      tick();
      do_word(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
    chk("wrap_count", word_count, 16'(mc & 255));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
